// File: rtl/divekick_pkg.sv
// Shared types and helpers for the DiveKick round controller.
// Defines the game state and round winner encodings and the frame counter width.
package divekick_pkg;

    localparam int FRAME_CNT_W = 12;

    typedef enum logic [2:0] {
        INTRO      = 3'd0,
        FIGHT      = 3'd1,
        FREEZE     = 3'd2,
        ROUND_OVER = 3'd3,
        MATCH_OVER = 3'd4
    } game_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2,
        DRAW = 2'd3
    } winner_t;

    // Round-win counter increment that holds at the match-winning value.
    function automatic logic [2:0] sat_inc(input logic [2:0] value, input logic [2:0] limit);
        return (value >= limit) ? limit : value + 3'd1;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous frame_clk level into the Clk domain and emits a one-Clk tick
// per frame; the tick lags the frame_clk rising edge by three Clk edges.
module frame_tick_gen (
    input  logic Clk,
    input  logic Reset_n,
    input  logic frame_clk,
    output logic tick
);

    logic sync_q1;
    logic sync_q2;
    logic level_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            level_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value,
            // so the chain really is three stages deep rather than collapsing into one.
            sync_q1 <= frame_clk;
            sync_q2 <= sync_q1;
            level_q <= sync_q2;
            tick    <= sync_q2 & ~level_q;
        end
    end

endmodule

// File: rtl/round_controller.sv
// DiveKick match sequencer: intro, fight, hit-freeze, round end, match end, restart.
// Optional round time limit and round_time output are enabled by defining ROUND_TIMER_EN.
module round_controller
    import divekick_pkg::*;
#(
    parameter int INTRO_FRAMES     = 90,
    parameter int FREEZE_FRAMES    = 30,
    parameter int ROUND_END_FRAMES = 120,
    parameter int WINS_TO_MATCH    = 3
`ifdef ROUND_TIMER_EN
    ,
    parameter int ROUND_FRAMES     = 3600
`endif
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       p1_hit,
    input  logic       p2_hit,
    input  logic       start_btn,
    output logic       Freeze,
    output logic       Restart,
    output logic [2:0] game_state,
    output logic [1:0] round_winner,
    output logic [2:0] p1_score,
    output logic [2:0] p2_score
`ifdef ROUND_TIMER_EN
    ,
    output logic [FRAME_CNT_W-1:0] round_time
`endif
);

    localparam logic [FRAME_CNT_W-1:0] INTRO_LAST     = FRAME_CNT_W'(INTRO_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] FREEZE_LAST    = FRAME_CNT_W'(FREEZE_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] ROUND_END_LAST = FRAME_CNT_W'(ROUND_END_FRAMES - 1);
    localparam logic [2:0]             WIN_LIMIT      = 3'(WINS_TO_MATCH);
`ifdef ROUND_TIMER_EN
    localparam logic [FRAME_CNT_W-1:0] ROUND_LAST     = FRAME_CNT_W'(ROUND_FRAMES - 1);
`endif

    logic tick;

    frame_tick_gen u_frame_tick_gen (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    game_state_t             state_q,   state_nxt;
    logic [FRAME_CNT_W-1:0]  cnt_q,     cnt_nxt;
    winner_t                 winner_q,  winner_nxt;
    logic [2:0]              p1_q,      p1_nxt;
    logic [2:0]              p2_q,      p2_nxt;
    logic                    restart_nxt;
    logic                    freeze_q;
    logic                    restart_q;

    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one
        // unassigned and no latch is inferred.
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        winner_nxt  = winner_q;
        p1_nxt      = p1_q;
        p2_nxt      = p2_q;
        restart_nxt = 1'b0;

        case (state_q)
            INTRO: begin
                if (tick) begin
                    if (cnt_q == INTRO_LAST) state_nxt = FIGHT;
                    else                     cnt_nxt   = cnt_q + FRAME_CNT_W'(1);
                end
            end

            FIGHT: begin
                if (tick) begin
                    if (p1_hit || p2_hit) begin
                        state_nxt = FREEZE;
                        if (p1_hit && !p2_hit) begin
                            winner_nxt = P1;
                            p1_nxt     = sat_inc(p1_q, WIN_LIMIT);
                        end else if (p2_hit && !p1_hit) begin
                            winner_nxt = P2;
                            p2_nxt     = sat_inc(p2_q, WIN_LIMIT);
                        end else begin
                            winner_nxt = DRAW;
                        end
                    end
`ifdef ROUND_TIMER_EN
                    // A hit on the final tick wins over the timeout draw.
                    else if (cnt_q == ROUND_LAST) begin
                        state_nxt  = FREEZE;
                        winner_nxt = DRAW;
                    end else begin
                        cnt_nxt = cnt_q + FRAME_CNT_W'(1);
                    end
`endif
                end
            end

            FREEZE: begin
                if (tick) begin
                    if (cnt_q == FREEZE_LAST) state_nxt = ROUND_OVER;
                    else                      cnt_nxt   = cnt_q + FRAME_CNT_W'(1);
                end
            end

            ROUND_OVER: begin
                if (tick) begin
                    if (cnt_q == ROUND_END_LAST) begin
                        if (p1_q == WIN_LIMIT || p2_q == WIN_LIMIT) begin
                            state_nxt = MATCH_OVER;
                        end else begin
                            state_nxt   = INTRO;
                            restart_nxt = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt_q + FRAME_CNT_W'(1);
                    end
                end
            end

            MATCH_OVER: begin
                if (tick && start_btn) begin
                    state_nxt   = INTRO;
                    p1_nxt      = 3'd0;
                    p2_nxt      = 3'd0;
                    winner_nxt  = NONE;
                    restart_nxt = 1'b1;
                end
            end

            default: state_nxt = INTRO;
        endcase

        // Each state starts counting from zero.
        if (state_nxt != state_q) cnt_nxt = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= INTRO;
            cnt_q     <= '0;
            winner_q  <= NONE;
            p1_q      <= 3'd0;
            p2_q      <= 3'd0;
            freeze_q  <= 1'b1;
            restart_q <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            winner_q  <= winner_nxt;
            p1_q      <= p1_nxt;
            p2_q      <= p2_nxt;
            // Freeze follows the state one cycle later; fighters only move in FIGHT.
            freeze_q  <= (state_q != FIGHT);
            restart_q <= restart_nxt;
        end
    end

    assign Freeze       = freeze_q;
    assign Restart      = restart_q;
    assign game_state   = state_q;
    assign round_winner = winner_q;
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;

`ifdef ROUND_TIMER_EN
    assign round_time = (state_q == FIGHT) ? (ROUND_LAST - cnt_q) : FRAME_CNT_W'(ROUND_FRAMES);
`endif

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: walks rounds, draws, a full match, restart and
// asynchronous reset; exercises the round timer when ROUND_TIMER_EN is defined.
module tb_round_controller;
    import divekick_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       p1_hit = 1'b0;
    logic       p2_hit = 1'b0;
    logic       start_btn = 1'b0;
    logic       Freeze;
    logic       Restart;
    logic [2:0] game_state;
    logic [1:0] round_winner;
    logic [2:0] p1_score;
    logic [2:0] p2_score;
`ifdef ROUND_TIMER_EN
    logic [11:0] round_time;
`endif

    int n_vec = 0;
    int n_err = 0;
    int restart_cnt = 0;
    int restart_dbl = 0;
    int restart_in_rst = 0;
    logic restart_prev = 1'b0;

    round_controller dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .p1_hit       (p1_hit),
        .p2_hit       (p2_hit),
        .start_btn    (start_btn),
        .Freeze       (Freeze),
        .Restart      (Restart),
        .game_state   (game_state),
        .round_winner (round_winner),
        .p1_score     (p1_score),
        .p2_score     (p2_score)
`ifdef ROUND_TIMER_EN
        ,
        .round_time   (round_time)
`endif
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Restart) restart_cnt++;
        if (Restart && restart_prev) restart_dbl++;
        if (Restart && !Reset_n) restart_in_rst++;
        restart_prev = Restart;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: frame_clk high for 4 Clk, low for 4 Clk; inputs held through the tick.
    task automatic frame(input logic h1, input logic h2, input logic st);
        @(negedge Clk);
        p1_hit = h1; p2_hit = h2; start_btn = st; frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0; p1_hit = 1'b0; p2_hit = 1'b0; start_btn = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) frame(1'b0, 1'b0, 1'b0);
    endtask

    int r0;

    initial begin
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        check("rst_state",  game_state,   INTRO);
        check("rst_freeze", Freeze,       1);
        check("rst_restart", Restart,     0);
        check("rst_scores", {p1_score, p2_score}, 0);
        check("rst_winner", round_winner, NONE);

        // Intro length
        idle(89);
        check("intro89_state",  game_state, INTRO);
        check("intro89_freeze", Freeze,     1);
        idle(1);
        check("intro90_state",  game_state, FIGHT);
        check("intro90_freeze", Freeze,     0);

        // Hit pulse between ticks is ignored
        @(negedge Clk); p1_hit = 1'b1;
        repeat (2) @(negedge Clk); p1_hit = 1'b0;
        repeat (4) @(negedge Clk);
        check("between_state", game_state, FIGHT);
        check("between_score", p1_score,   0);

        // P1 wins the round
        r0 = restart_cnt;
        frame(1'b1, 1'b0, 1'b0);
        check("p1hit_state",  game_state,   FREEZE);
        check("p1hit_p1",     p1_score,     1);
        check("p1hit_p2",     p2_score,     0);
        check("p1hit_winner", round_winner, P1);
        check("p1hit_freeze", Freeze,       1);
        frame(1'b1, 1'b0, 1'b0);
        check("freeze_hit_score", p1_score,   1);
        check("freeze_hit_state", game_state, FREEZE);
        idle(28);
        check("freeze29_state", game_state, FREEZE);
        idle(1);
        check("freeze30_state", game_state, ROUND_OVER);
        idle(119);
        check("rover119_state",   game_state,  ROUND_OVER);
        check("rover119_restart", restart_cnt, r0);
        idle(1);
        check("rover120_state",   game_state,  INTRO);
        check("rover120_restart", restart_cnt, r0 + 1);

        // Simultaneous hits draw
        idle(90);
        check("draw_fight", game_state, FIGHT);
        frame(1'b1, 1'b1, 1'b0);
        check("draw_state",  game_state,   FREEZE);
        check("draw_winner", round_winner, DRAW);
        check("draw_p1",     p1_score,     1);
        check("draw_p2",     p2_score,     0);
        idle(150);
        check("draw_next_state", game_state,  INTRO);
        check("draw_restart",    restart_cnt, r0 + 2);

        // P2 takes three rounds and the match
        for (int i = 0; i < 3; i++) begin
            idle(90);
            frame(1'b0, 1'b1, 1'b0);
            check("p2round_score",  p2_score,     i + 1);
            check("p2round_winner", round_winner, P2);
            idle(150);
            check("p2round_state", game_state, (i < 2) ? INTRO : MATCH_OVER);
        end
        check("match_restarts", restart_cnt, r0 + 4);
        check("match_p1",       p1_score,    1);
        idle(5);
        check("match_hold", game_state, MATCH_OVER);
        frame(1'b1, 1'b0, 1'b0);
        check("match_hit_ignored", p1_score, 1);
        frame(1'b0, 1'b0, 1'b1);
        check("start_state",   game_state,   INTRO);
        check("start_scores",  {p1_score, p2_score}, 0);
        check("start_winner",  round_winner, NONE);
        check("start_restart", restart_cnt,  r0 + 5);

        // start_btn in INTRO only counts as an ordinary tick
        frame(1'b0, 1'b0, 1'b1);
        check("start_intro_state", game_state,  INTRO);
        check("start_intro_rst",   restart_cnt, r0 + 5);
        idle(88);
        check("intro_again_89", game_state, INTRO);
        idle(1);
        check("intro_again_90", game_state, FIGHT);

        // Score a point, then reset in the middle of the next fight
        frame(1'b0, 1'b1, 1'b0);
        idle(150);
        idle(90);
        check("pre_reset_state", game_state, FIGHT);
        check("pre_reset_p2",    p2_score,   1);
        r0 = restart_cnt;
        @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_state",   game_state, INTRO);
        check("async_rst_scores",  {p1_score, p2_score}, 0);
        check("async_rst_freeze",  Freeze,     1);
        check("async_rst_restart", Restart,    0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clk);
        check("post_rst_restart_cnt", restart_cnt, r0);

`ifdef ROUND_TIMER_EN
        check("timer_intro", round_time, 3600);
        idle(90);
        check("timer_fight_state", game_state, FIGHT);
        check("timer_start",       round_time, 3599);
        idle(3599);
        check("timer_last_state", game_state, FIGHT);
        check("timer_zero",       round_time, 0);
        idle(1);
        check("timeout_state",  game_state,   FREEZE);
        check("timeout_winner", round_winner, DRAW);
        check("timeout_scores", {p1_score, p2_score}, 0);
        check("timeout_time",   round_time,   3600);
`endif

        check("restart_double", restart_dbl,    0);
        check("restart_in_rst", restart_in_rst, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
